// File: rtl/chi_rx_link_buffer.sv
// CHI receive-side link buffer: link activation handshake, L-credit issue,
// credit-return filtering and a small first-word-fall-through flit FIFO
// feeding one HN rx channel.

// Occupancy checks: spare capacity never negative, credits plus stored
// flits never exceed the buffer depth.
module chi_rx_link_buffer_chk #(
  parameter int CW    = 3,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rstn,
  input logic signed [AW-1:0] avail,
  input logic [CW-1:0]        credits,
  input logic [CW-1:0]        count
);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  avail_nonneg: assert property (@(posedge clk) disable iff (!rstn) !avail[AW-1]);

  occupancy_bound: assert property (@(posedge clk) disable iff (!rstn)
    (({1'b0, credits} + {1'b0, count}) <= DEPTH_C));
endmodule

module chi_rx_link_buffer #(
  parameter int FLIT_W  = 128,
  parameter int DEPTH   = 4,
  parameter int OPC_LSB = 0,
  parameter int OPC_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_linkactivereq,
  output logic              rx_linkactiveack,
  input  logic              rx_flitv,
  input  logic [FLIT_W-1:0] rx_flit,
  output logic              rx_lcrdv,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  output logic              proto_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = CW + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    STOP       = 2'd0,
    ACTIVATE   = 2'd1,
    RUN        = 2'd2,
    DEACTIVATE = 2'd3
  } link_state_t;

  link_state_t        state_r;
  logic               ack_r;
  logic               lcrdv_r;
  logic               proto_err_r;
  logic               out_valid_r;
  logic [FLIT_W-1:0]  out_flit_r;
  logic [CW-1:0]      credits_r;
  logic [CW-1:0]      count_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [FLIT_W-1:0]  mem_r [DEPTH];

  logic signed [AW-1:0] avail_s;
  logic [OPC_W-1:0]     opcode_s;
  logic                 has_credit_s;
  logic                 grant_s;
  logic                 take_s;
  logic                 push_s;
  logic                 pop_s;
  logic [CW-1:0]        count_next_s;
  logic [FLIT_W-1:0]    head_next_s;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign avail_s      = $signed(DEPTH_A - {1'b0, credits_r} - {1'b0, count_r});
  assign opcode_s     = rx_flit[OPC_LSB +: OPC_W];
  assign has_credit_s = (credits_r != {CW{1'b0}});
  assign grant_s      = (state_r == RUN) && !avail_s[AW-1] && (avail_s != {AW{1'b0}});
  assign take_s       = rx_flitv && has_credit_s;
  assign push_s       = take_s && (opcode_s != {OPC_W{1'b0}});
  assign pop_s        = out_valid_r && out_ready;

  // Next FIFO occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Next head flit: the following entry after a pop, or a bypassed incoming
  // flit when the store is (or becomes) empty.
  always_comb begin
    head_next_s = out_flit_r;
    if (pop_s) begin
      if (count_r > CW'(1)) begin
        head_next_s = mem_r[ptr_inc(rd_ptr_r)];
      end else if (push_s) begin
        head_next_s = rx_flit;
      end else begin
        head_next_s = {FLIT_W{1'b0}};
      end
    end else if (count_r == {CW{1'b0}}) begin
      if (push_s) begin
        head_next_s = rx_flit;
      end else begin
        head_next_s = {FLIT_W{1'b0}};
      end
    end else begin
      head_next_s = out_flit_r;
    end
  end

  // Link activation FSM; ack is registered and tracks the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= STOP;
      ack_r   <= 1'b0;
    end else begin
      case (state_r)
        STOP: begin
          if (rx_linkactivereq) begin
            state_r <= ACTIVATE;
            ack_r   <= 1'b1;
          end else begin
            ack_r   <= 1'b0;
          end
        end
        ACTIVATE: begin
          state_r <= RUN;
          ack_r   <= 1'b1;
        end
        RUN: begin
          if (!rx_linkactivereq) begin
            state_r <= DEACTIVATE;
          end
          ack_r <= 1'b1;
        end
        DEACTIVATE: begin
          if (credits_r == {CW{1'b0}}) begin
            state_r <= STOP;
            ack_r   <= 1'b0;
          end else begin
            ack_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= STOP;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Credit accounting, credit pulse and sticky protocol error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits_r   <= {CW{1'b0}};
      lcrdv_r     <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      case ({grant_s, take_s})
        2'b10:   credits_r <= credits_r + CW'(1);
        2'b01:   credits_r <= credits_r - CW'(1);
        default: credits_r <= credits_r;
      endcase
      lcrdv_r <= grant_s;
      if (rx_flitv && !has_credit_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {FLIT_W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= rx_flit;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
    end
  end

  // Registered head-of-queue presentation to the HN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_flit_r  <= {FLIT_W{1'b0}};
    end else begin
      out_valid_r <= (count_next_s != {CW{1'b0}});
      out_flit_r  <= head_next_s;
    end
  end

  assign rx_linkactiveack = ack_r;
  assign rx_lcrdv         = lcrdv_r;
  assign proto_err        = proto_err_r;
  assign out_valid        = out_valid_r;
  assign out_flit         = out_flit_r;

  chi_rx_link_buffer_chk #(.CW(CW), .AW(AW), .DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rstn    (rstn),
    .avail   (avail_s),
    .credits (credits_r),
    .count   (count_r)
  );
endmodule

// File: tb/tb_chi_rx_link_buffer.sv
// Directed bench for chi_rx_link_buffer with a queue-based reference model
// compared every cycle, plus hand-computed cycle-exact expectations.
module tb_chi_rx_link_buffer;
  localparam int FLIT_W = 128;
  localparam int DEPTH  = 4;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;

  logic              clk;
  logic              rstn;
  logic              rx_linkactivereq;
  logic              rx_linkactiveack;
  logic              rx_flitv;
  logic [FLIT_W-1:0] rx_flit;
  logic              rx_lcrdv;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic              out_ready;
  logic              proto_err;

  int vectors    = 0;
  int miscompares = 0;

  chi_rx_link_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .OPC_LSB(0), .OPC_W(4)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .rx_linkactivereq (rx_linkactivereq),
    .rx_linkactiveack (rx_linkactiveack),
    .rx_flitv         (rx_flitv),
    .rx_flit          (rx_flit),
    .rx_lcrdv         (rx_lcrdv),
    .out_valid        (out_valid),
    .out_flit         (out_flit),
    .out_ready        (out_ready),
    .proto_err        (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [3:0] opc, input logic [7:0] tag);
    return {{15{tag}}, 4'hC, opc};
  endfunction

  // Reference model: credit count, queue of buffered flits, link phase.
  int                m_phase;
  int                m_credits;
  logic [FLIT_W-1:0] m_q[$];
  logic              m_ack;
  logic              m_lcrdv;
  logic              m_err;

  initial begin
    int avail;
    bit grant, took, err, pop;
    logic [FLIT_W-1:0] dummy;
    m_phase = M_IDLE; m_credits = 0; m_q.delete();
    m_ack = 1'b0; m_lcrdv = 1'b0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_phase = M_IDLE; m_credits = 0; m_q.delete();
        m_ack = 1'b0; m_lcrdv = 1'b0; m_err = 1'b0;
      end
      check("mdl_ack", {127'd0, rx_linkactiveack}, {127'd0, m_ack});
      check("mdl_lcrdv", {127'd0, rx_lcrdv}, {127'd0, m_lcrdv});
      check("mdl_proto_err", {127'd0, proto_err}, {127'd0, m_err});
      check("mdl_out_valid", {127'd0, out_valid}, {127'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) check("mdl_out_flit", out_flit, m_q[0]);
      if (rstn) begin
        avail = DEPTH - m_credits - m_q.size();
        grant = (m_phase == M_RUN) && (avail > 0);
        took  = rx_flitv && (m_credits > 0);
        err   = rx_flitv && (m_credits == 0);
        pop   = (m_q.size() != 0) && out_ready;
        if (pop) dummy = m_q.pop_front();
        if (took && (rx_flit[3:0] != 4'd0)) m_q.push_back(rx_flit);
        m_credits = m_credits + (grant ? 1 : 0) - (took ? 1 : 0);
        m_lcrdv = grant;
        m_err = m_err | err;
        case (m_phase)
          M_IDLE:  if (rx_linkactivereq) m_phase = M_UP;
          M_UP:    m_phase = M_RUN;
          M_RUN:   if (!rx_linkactivereq) m_phase = M_DOWN;
          M_DOWN:  if (m_credits + (took ? 1 : 0) == 0) m_phase = M_IDLE;
          default: m_phase = M_IDLE;
        endcase
        m_ack = (m_phase != M_IDLE);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FLIT_W-1:0] f);
    rx_flitv = 1'b1;
    rx_flit  = f;
    tick();
    rx_flitv = 1'b0;
    rx_flit  = '0;
  endtask

  initial begin
    int n;
    rstn = 1'b0; rx_linkactivereq = 1'b0; rx_flitv = 1'b0; rx_flit = '0; out_ready = 1'b1;
    #1;
    check("rst_ack", {127'd0, rx_linkactiveack}, 128'd0);
    check("rst_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_proto", {127'd0, proto_err}, 128'd0);
    check("rst_flit", out_flit, 128'd0);
    tick(); tick();

    // Activation and credit fill; req seen in cycle 0.
    rstn = 1'b1; rx_linkactivereq = 1'b1;
    check("act_c0_ack", {127'd0, rx_linkactiveack}, 128'd0);
    tick(); check("act_c1_ack", {127'd0, rx_linkactiveack}, 128'd1);
    check("act_c1_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    tick(); check("act_c2_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    for (int c = 3; c <= 6; c++) begin
      tick(); check("act_fill_lcrdv", {127'd0, rx_lcrdv}, 128'd1);
    end
    tick(); check("act_c7_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    tick(); check("act_c8_lcrdv", {127'd0, rx_lcrdv}, 128'd0);

    // Backpressure to full.
    out_ready = 1'b0;
    send(mk(4'd1, 8'h10));
    check("bp_valid_first", {127'd0, out_valid}, 128'd1);
    check("bp_head_first", out_flit, mk(4'd1, 8'h10));
    send(mk(4'd2, 8'h21));
    send(mk(4'd3, 8'h32));
    send(mk(4'd4, 8'h43));
    tick(); tick();
    check("bp_head_hold", out_flit, mk(4'd1, 8'h10));
    check("bp_no_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    out_ready = 1'b1;
    check("drain_f0", out_flit, mk(4'd1, 8'h10));
    n = 0;
    tick(); check("drain_f1", out_flit, mk(4'd2, 8'h21)); n += int'(rx_lcrdv);
    tick(); check("drain_f2", out_flit, mk(4'd3, 8'h32)); n += int'(rx_lcrdv);
    tick(); check("drain_f3", out_flit, mk(4'd4, 8'h43)); n += int'(rx_lcrdv);
    tick(); check("drain_empty", {127'd0, out_valid}, 128'd0); n += int'(rx_lcrdv);
    for (int i = 0; i < 4; i++) begin tick(); n += int'(rx_lcrdv); end
    check("drain_recredit_cnt", 128'(n), 128'd4);

    // Credit-return flits are consumed, credits re-issued.
    send(mk(4'd0, 8'h55));
    send(mk(4'd0, 8'h66));
    check("crd_ret_valid", {127'd0, out_valid}, 128'd0);
    n = int'(rx_lcrdv);
    for (int i = 0; i < 7; i++) begin tick(); n += int'(rx_lcrdv); end
    check("crd_ret_cnt", 128'(n), 128'd2);

    // Deactivation with 4 credits outstanding.
    rx_linkactivereq = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(); n += int'(rx_lcrdv); end
    check("deact_no_lcrdv", 128'(n), 128'd0);
    for (int i = 0; i < 4; i++) begin
      check("deact_ack_hold", {127'd0, rx_linkactiveack}, 128'd1);
      send(mk(4'd0, 8'h70 + 8'(i)));
    end
    tick();
    check("deact_ack_low", {127'd0, rx_linkactiveack}, 128'd0);

    // Protocol error in STOP with no credits.
    send(mk(4'd3, 8'h99));
    check("perr_set", {127'd0, proto_err}, 128'd1);
    check("perr_no_valid", {127'd0, out_valid}, 128'd0);
    tick(); tick();
    check("perr_sticky", {127'd0, proto_err}, 128'd1);

    // Reset mid-stream with 3 flits buffered.
    rstn = 1'b0; tick();
    rstn = 1'b1; rx_linkactivereq = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    send(mk(4'd5, 8'hA1));
    send(mk(4'd6, 8'hB2));
    send(mk(4'd7, 8'hC3));
    check("mid_buffered", {127'd0, out_valid}, 128'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_ack", {127'd0, rx_linkactiveack}, 128'd0);
    check("mid_rst_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    check("mid_rst_proto", {127'd0, proto_err}, 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1;
    tick(); check("restart_c1_ack", {127'd0, rx_linkactiveack}, 128'd1);
    tick(); check("restart_c2_lcrdv", {127'd0, rx_lcrdv}, 128'd0);
    tick(); check("restart_c3_lcrdv", {127'd0, rx_lcrdv}, 128'd1);
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
